// File: rtl/sim_controller.sv
// Simulation controller: serialises cursor-click cell toggles (read-modify-write) and paced
// generation-step requests to the life engine. Optional single-step button: define SINGLE_STEP_EN.
module sim_controller #(
    parameter int LOG_BASE_PERIOD = 22,
    parameter int LOG_BOARD_SIZE  = 6,
    parameter int LOG_MAX_SPEED   = 4
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      click_in,
    input  logic [LOG_MAX_SPEED-1:0]  speed_in,
    input  logic [LOG_BOARD_SIZE-1:0] cursor_x_in,
    input  logic [LOG_BOARD_SIZE-1:0] cursor_y_in,
    output logic [LOG_BOARD_SIZE-1:0] rd_x_out,
    output logic [LOG_BOARD_SIZE-1:0] rd_y_out,
    input  logic                      rd_data_in,
    output logic                      wr_en_out,
    output logic [LOG_BOARD_SIZE-1:0] wr_x_out,
    output logic [LOG_BOARD_SIZE-1:0] wr_y_out,
    output logic                      wr_data_out,
    output logic                      step_req_out,
    input  logic                      step_ack_in,
    input  logic                      engine_busy_in,
`ifdef SINGLE_STEP_EN
    input  logic                      step_btn_in,
`endif
    output logic                      paused_out
);

    typedef enum logic [2:0] {
        IDLE,
        EDIT_RD,
        EDIT_WR,
        STEP_REQ,
        STEP_WAIT
    } state_t;

    state_t                      state_q, state_d;
    logic [LOG_BASE_PERIOD-1:0]  presc_q, presc_d;
    logic [LOG_MAX_SPEED-1:0]    acc_q, acc_d;
    logic                        step_pend_q, step_pend_d;
    logic                        edit_pend_q, edit_pend_d;
    logic [LOG_BOARD_SIZE-1:0]   edit_x_q, edit_x_d;
    logic [LOG_BOARD_SIZE-1:0]   edit_y_q, edit_y_d;
    logic                        click_prev_q, click_prev_d;
`ifdef SINGLE_STEP_EN
    logic                        btn_prev_q, btn_prev_d;
`endif

    logic paused;
    logic carry;
    logic click_rise;

    assign paused     = (speed_in == '0);
    assign paused_out = paused;

    // NOTE: every signal written here gets a default first, so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        acc_d        = acc_q;
        step_pend_d  = step_pend_q;
        edit_pend_d  = edit_pend_q;
        edit_x_d     = edit_x_q;
        edit_y_d     = edit_y_q;
        click_prev_d = click_in;
        carry        = 1'b0;
        rd_x_out     = '0;
        rd_y_out     = '0;
        wr_en_out    = 1'b0;
        wr_x_out     = '0;
        wr_y_out     = '0;
        wr_data_out  = 1'b0;
        step_req_out = 1'b0;

        // Paused holds the pacing chain at zero so a resumed speed starts a fresh period.
        if (paused) begin
            presc_d = '0;
            acc_d   = '0;
        end else begin
            presc_d = presc_q + 1'b1;
            if (&presc_q) begin
                {carry, acc_d} = {1'b0, acc_q} + {1'b0, speed_in};
            end
        end

        click_rise = click_in & ~click_prev_q;
        if (click_rise && !edit_pend_q) begin
            edit_pend_d = 1'b1;
            edit_x_d    = cursor_x_in;
            edit_y_d    = cursor_y_in;
        end

        case (state_q)
            IDLE: begin
                if (edit_pend_q) begin
                    state_d = EDIT_RD;
                end else if (step_pend_q) begin
                    state_d = STEP_REQ;
                end
            end
            EDIT_RD: begin
                rd_x_out = edit_x_q;
                rd_y_out = edit_y_q;
                state_d  = EDIT_WR;
            end
            EDIT_WR: begin
                rd_x_out    = edit_x_q;
                rd_y_out    = edit_y_q;
                wr_en_out   = 1'b1;
                wr_x_out    = edit_x_q;
                wr_y_out    = edit_y_q;
                wr_data_out = ~rd_data_in;
                edit_pend_d = 1'b0;
                state_d     = IDLE;
            end
            STEP_REQ: begin
                step_req_out = 1'b1;
                if (step_ack_in) begin
                    step_pend_d = 1'b0;
                    state_d     = STEP_WAIT;
                end
            end
            STEP_WAIT: begin
                if (!engine_busy_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A carry landing on an already pending step merges into it; one landing on
        // the accept cycle is a new step and survives the clear above.
        if (carry) begin
            step_pend_d = 1'b1;
        end

`ifdef SINGLE_STEP_EN
        btn_prev_d = step_btn_in;
        if (step_btn_in && !btn_prev_q && paused) begin
            step_pend_d = 1'b1;
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            acc_q        <= '0;
            step_pend_q  <= 1'b0;
            edit_pend_q  <= 1'b0;
            edit_x_q     <= '0;
            edit_y_q     <= '0;
            click_prev_q <= 1'b0;
`ifdef SINGLE_STEP_EN
            btn_prev_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            acc_q        <= acc_d;
            step_pend_q  <= step_pend_d;
            edit_pend_q  <= edit_pend_d;
            edit_x_q     <= edit_x_d;
            edit_y_q     <= edit_y_d;
            click_prev_q <= click_prev_d;
`ifdef SINGLE_STEP_EN
            btn_prev_q   <= btn_prev_d;
`endif
        end
    end

endmodule

// File: tb/tb_sim_controller.sv
// Scoreboard bench for sim_controller: a board memory and engine responder drive the DUT,
// expected writes and request times are queued at stimulus time and checked by a monitor.
module tb_sim_controller;

    localparam int LBP  = 2;
    localparam int LBS  = 4;
    localparam int LMS  = 4;
    localparam int BS   = 1 << LBS;
    localparam int SMAX = (1 << LMS) - 1;
    localparam int TICK = 1 << LBP;

    logic           clk;
    logic           rst_n;
    logic           click;
    logic [LMS-1:0] speed;
    logic [LBS-1:0] cur_x, cur_y;
    logic [LBS-1:0] rd_x_out, rd_y_out, wr_x_out, wr_y_out;
    logic           rd_data;
    logic           wr_en_out, wr_data_out, step_req_out, paused_out;
    logic           ack, busy;
`ifdef SINGLE_STEP_EN
    logic           step_btn;
`endif

    sim_controller #(
        .LOG_BASE_PERIOD(LBP),
        .LOG_BOARD_SIZE (LBS),
        .LOG_MAX_SPEED  (LMS)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst_n),
        .click_in      (click),
        .speed_in      (speed),
        .cursor_x_in   (cur_x),
        .cursor_y_in   (cur_y),
        .rd_x_out      (rd_x_out),
        .rd_y_out      (rd_y_out),
        .rd_data_in    (rd_data),
        .wr_en_out     (wr_en_out),
        .wr_x_out      (wr_x_out),
        .wr_y_out      (wr_y_out),
        .wr_data_out   (wr_data_out),
        .step_req_out  (step_req_out),
        .step_ack_in   (ack),
        .engine_busy_in(busy),
`ifdef SINGLE_STEP_EN
        .step_btn_in   (step_btn),
`endif
        .paused_out    (paused_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial forever @(posedge clk) cyc++;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    typedef struct {
        int x;
        int y;
        bit d;
        int at;
    } wr_t;

    wr_t wr_q[$];
    int  step_q[$];
    bit  mem   [BS][BS];
    bit  model [BS][BS];
    int  req_count = 0;
    int  last_wr_cyc = 0;
    int  last_req_cyc = 0;
    logic req_prev = 1'b0;

    // Monitor: pops the expectation queues whenever the DUT issues a write or a new request.
    initial forever begin
        @(negedge clk);
        if (rst_n && wr_en_out) begin
            if (wr_q.size() == 0) begin
                fail("unexpected_write");
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check("wr_x", wr_x_out, e.x);
                check("wr_y", wr_y_out, e.y);
                check("wr_data", wr_data_out, e.d);
                if (e.at >= 0) check("wr_cycle", cyc, e.at);
            end
            mem[wr_x_out][wr_y_out] = wr_data_out;
            last_wr_cyc = cyc;
        end
        if (rst_n && step_req_out && !req_prev) begin
            if (step_q.size() == 0) begin
                fail("unexpected_step_req");
            end else begin
                int e;
                e = step_q.pop_front();
                if (e >= 0) check("req_cycle", cyc, e);
            end
            req_count++;
            last_req_cyc = cyc;
        end
        req_prev = step_req_out;
    end

    // Board memory: read data appears the cycle after the address.
    bit rd_next;
    initial begin
        rd_data = 1'b0;
        forever begin
            @(negedge clk);
            rd_next = mem[rd_x_out][rd_y_out];
            @(posedge clk);
            #1 rd_data = rd_next;
        end
    end

    // Engine responder: acks after ack_hold request cycles, then stays busy for busy_len cycles.
    int ack_hold = 0;
    int busy_len = 0;
    int hold_cnt = 0;
    int hold_at_ack = 0;
    int busy_left = 0;
    int busy_fall_cyc = 0;
    initial begin
        ack  = 1'b0;
        busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ack = 1'b0; busy = 1'b0; hold_cnt = 0; busy_left = 0;
            end else if (ack) begin
                ack = 1'b0;
                busy_left = busy_len;
                if (busy_left == 0) begin busy = 1'b0; busy_fall_cyc = cyc; end
            end else if (busy) begin
                busy_left--;
                if (busy_left <= 0) begin busy = 1'b0; busy_fall_cyc = cyc; end
            end else if (step_req_out) begin
                hold_cnt++;
                if (hold_cnt > ack_hold) begin
                    ack = 1'b1; busy = 1'b1; hold_at_ack = hold_cnt; hold_cnt = 0;
                end
            end
        end
    end

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while ((wr_q.size() != 0 || step_q.size() != 0 || busy || ack || step_req_out) && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (i >= budget) fail("drain_timeout");
        repeat (3) @(negedge clk);
    endtask

    // Click at (x,y): the cell must toggle three cycles later when the FSM is idle.
    task automatic press(input int x, input int y, input bit timed);
        wr_t e;
        int  t0;
        cur_x = LBS'(x);
        cur_y = LBS'(y);
        click = 1'b1;
        t0    = cyc;
        e.x = x; e.y = y; e.d = ~model[x][y]; e.at = timed ? t0 + 3 : -1;
        wr_q.push_back(e);
        model[x][y] = ~model[x][y];
        @(negedge clk);
        if (timed) begin
            check("rd_x_idle", rd_x_out, 0);
            check("rd_y_idle", rd_y_out, 0);
        end
        click = 1'b0;
        cur_x = LBS'($urandom_range(0, BS - 1));
        cur_y = LBS'($urandom_range(0, BS - 1));
        @(negedge clk);
        if (timed) begin
            check("rd_x", rd_x_out, x);
            check("rd_y", rd_y_out, y);
        end
    endtask

    // Constant speed s from a cleared accumulator: tick n lands n*TICK cycles in and carries
    // whenever floor(n*s / 2**LMS) steps up; the request is visible one cycle later.
    task automatic pace_segment(input int s, input int nt);
        int c0;
        speed = LMS'(s);
        c0    = cyc;
        for (int n = 1; n <= nt; n++) begin
            if ((n * s) / (SMAX + 1) > ((n - 1) * s) / (SMAX + 1))
                step_q.push_back(c0 + n * TICK + 1);
        end
        while (cyc < c0 + nt * TICK + 2) @(negedge clk);
        speed = '0;
        wait_drain(200);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int r0;
        int i;
        rst_n = 1'b0;
        click = 1'b1;
        speed = LMS'(SMAX);
        cur_x = 4'd3;
        cur_y = 4'd3;
`ifdef SINGLE_STEP_EN
        step_btn = 1'b0;
`endif
        for (int x = 0; x < BS; x++)
            for (int y = 0; y < BS; y++) begin
                mem[x][y]   = 1'($urandom_range(0, 1));
                model[x][y] = mem[x][y];
            end

        // Reset holds every output low even with click and full speed applied.
        repeat (8) begin
            @(negedge clk);
            check("reset_outputs", {rd_x_out, rd_y_out, wr_en_out, wr_x_out, wr_y_out,
                                    wr_data_out, step_req_out, paused_out}, 0);
        end
        click = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pace_segment(SMAX, 6);

        // Directed toggle of (5,9): 0 -> 1 -> 0.
        mem[5][9]   = 1'b0;
        model[5][9] = 1'b0;
        press(5, 9, 1'b1);
        wait_drain(50);
        press(5, 9, 1'b1);
        wait_drain(50);

        // Random toggles.
        repeat (8) begin
            press($urandom_range(0, BS - 1), $urandom_range(0, BS - 1), 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            wait_drain(50);
        end

        // Pacing: speed 1 gives one request every TICK * 2**LMS cycles, then random speeds.
        pace_segment(1, 2 * (SMAX + 1));
        repeat (3) pace_segment($urandom_range(1, SMAX), $urandom_range(10, 30));

        // Paused: no requests for 10000 cycles.
        speed = '0;
        r0 = req_count;
        repeat (10000) @(negedge clk);
        check("paused_out", paused_out, 1);
        check("paused_req_count", req_count, r0);

        // Held-off ack: request stays up, extra carries merge, then a long busy.
        ack_hold = 50;
        busy_len = 20;
        r0 = req_count;
        step_q.push_back(-1);
        speed = LMS'(SMAX);
        i = 0;
        while (!(step_req_out && hold_cnt >= 40) && i < 200) begin @(negedge clk); i++; end
        if (i >= 200) fail("req_hold_timeout");
        speed = '0;
        i = 0;
        while (!ack && i < 100) begin @(negedge clk); i++; end
        if (i >= 100) fail("ack_timeout");
        check("req_held_cycles", hold_at_ack, 51);
        repeat (3) @(negedge clk);
        check("busy_during_wait", busy, 1);
        press(3, 7, 1'b0);
        cur_x = 4'd10;
        cur_y = 4'd2;
        click = 1'b1;
        @(negedge clk);
        click = 1'b0;
        wait_drain(100);
        check("edit_after_busy", last_wr_cyc > busy_fall_cyc, 1);
        check("single_step_from_hold", req_count, r0 + 1);
        ack_hold = 0;
        busy_len = 0;

        // Click edge and carry in the same cycle: the edit goes first.
        speed = LMS'(8);
        r0 = cyc;
        step_q.push_back(r0 + 2 * TICK + 4);
        while (cyc < r0 + 2 * TICK - 1) @(negedge clk);
        press(12, 1, 1'b1);
        while (cyc < r0 + 3 * TICK + 1) @(negedge clk);
        speed = '0;
        wait_drain(100);
        check("write_before_req", last_wr_cyc < last_req_cyc, 1);

        // Reset mid-handshake drops the request and the pending edit.
        ack_hold = 1000;
        step_q.push_back(-1);
        speed = LMS'(SMAX);
        i = 0;
        while (!step_req_out && i < 100) begin @(negedge clk); i++; end
        if (i >= 100) fail("req_before_reset_timeout");
        speed = '0;
        cur_x = 4'd6;
        cur_y = 4'd6;
        click = 1'b1;
        @(negedge clk);
        click = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("req_dropped_on_reset", step_req_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ack_hold = 0;
        r0 = req_count;
        repeat (30) @(negedge clk);
        check("nothing_after_reset", req_count, r0);

`ifdef SINGLE_STEP_EN
        // Single-step button: one generation per press while paused, ignored while running.
        speed = '0;
        r0 = req_count;
        repeat (3) begin
            step_q.push_back(-1);
            step_btn = 1'b1;
            repeat (2) @(negedge clk);
            step_btn = 1'b0;
            repeat (10) @(negedge clk);
        end
        wait_drain(100);
        check("single_step_count", req_count, r0 + 3);
        speed = LMS'(4);
        step_btn = 1'b1;
        repeat (2) @(negedge clk);
        speed = '0;
        step_btn = 1'b0;
        repeat (20) @(negedge clk);
        check("single_step_running", req_count, r0 + 3);
`endif

        wait_drain(100);
        check("wr_queue_empty", wr_q.size(), 0);
        check("step_queue_empty", step_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sim_controller.md
Name: sim_controller

Overview:
- Sits directly downstream of the user-interface stage and consumes its debounced click, speed and cursor outputs.
- Converts a click into a single read-modify-write toggle of the board cell under the cursor.
- Converts the speed setting into paced generation-step requests to the life engine, using a req/ack/busy handshake.
- Serialises edits and steps so that the board memory is never edited while the engine is stepping.

Parameters:
- LOG_BASE_PERIOD, default 22: prescaler width; one base tick every 2**LOG_BASE_PERIOD cycles.
- Board coordinate width is LOG_BOARD_SIZE and speed width is LOG_MAX_SPEED, both from common.svh.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- click_in  input  1  debounced click level.
- speed_in  input  LOG_MAX_SPEED  step rate; 0 = paused.
- cursor_x_in  input  LOG_BOARD_SIZE  cursor column.
- cursor_y_in  input  LOG_BOARD_SIZE  cursor row.
- rd_x_out  output  LOG_BOARD_SIZE  board read column.
- rd_y_out  output  LOG_BOARD_SIZE  board read row.
- rd_data_in  input  1  cell value; valid the cycle after the address is presented.
- wr_en_out  output  1  board write strobe, 1 cycle.
- wr_x_out  output  LOG_BOARD_SIZE  write column.
- wr_y_out  output  LOG_BOARD_SIZE  write row.
- wr_data_out  output  1  write value.
- step_req_out  output  1  request one generation step.
- step_ack_in  input  1  engine accepted request.
- engine_busy_in  input  1  engine is computing a generation.
- paused_out  output  1  high when speed_in == 0.

Behaviour:
- Reset (rst_in low, asynchronous): all outputs 0, FSM in IDLE, prescaler/accumulator/pending flags/latched coordinates cleared, click edge register cleared. Asserting reset mid-handshake drops the request immediately. No edit or step survives reset.
- Pacing:
  - The prescaler counts every cycle while speed_in != 0 and emits a base tick on wrap (all ones -> 0).
  - On each base tick, acc (LOG_MAX_SPEED bits) <= acc + speed_in. A carry out of the MSB sets step_pend.
  - With speed_in == 0, the prescaler and acc are held at 0; step_pend is unaffected.
  - If a carry occurs while step_pend is already set, that step is dropped (no queueing beyond 1).
- Click:
  - A rising edge of click_in (registered previous value, 1-cycle detect) with edit_pend clear sets edit_pend and latches cursor_x_in/cursor_y_in in the same cycle.
  - Edges while edit_pend is set are ignored. Later cursor motion does not affect the latched address.
- FSM states: IDLE, EDIT_RD, EDIT_WR, STEP_REQ, STEP_WAIT.
  - IDLE: if edit_pend, go to EDIT_RD (edit has priority); else if step_pend, go to STEP_REQ.
  - EDIT_RD: drive rd_x/rd_y = latched coordinates for exactly 1 cycle, then go to EDIT_WR. rd_x/rd_y hold the latched coordinates while in EDIT_WR and are otherwise 0.
  - EDIT_WR: wr_en_out = 1 for 1 cycle, wr_x/wr_y = latched coordinates, wr_data_out = ~rd_data_in. Clear edit_pend and go to IDLE.
  - Edit latency: 3 cycles from the click edge sampled in IDLE to the write strobe.
  - STEP_REQ: step_req_out held high until step_ack_in is sampled high. On ack, step_req_out drops the next cycle, step_pend clears and the FSM goes to STEP_WAIT. An ack in the first STEP_REQ cycle is legal.
  - STEP_WAIT: stay until engine_busy_in is low, then go to IDLE. Edits arriving during STEP_REQ/STEP_WAIT stay pending and are serviced in IDLE afterwards.
- Simultaneous new step carry and edit edge in the same cycle: both pend flags set, and the edit is serviced first.
- paused_out is combinational: speed_in == 0.

Optional Feature:
- Macro SINGLE_STEP_EN.
- Defined: adds input step_btn_in (1 bit, debounced). A rising edge of step_btn_in while speed_in == 0 sets step_pend, giving exactly one generation per press; the edge is ignored when speed_in != 0.
- Not defined: the port is absent and steps come only from pacing.

Test Plan:
- Reset: hold rst_in low with click_in=1 and speed_in=max; all outputs stay 0. Release reset; no write occurs and no request appears before the first carry.
- Toggle: cursor=(5,9), rd_data_in=0, rising edge of click_in -> rd_x/rd_y=(5,9) on the cycle after the edge, wr_en_out=1 with (5,9), data=1, 3 cycles after the edge. Repeating with rd_data_in=1 writes 0.
- Pacing: LOG_BASE_PERIOD=2, speed_in=1, ack returned 1 cycle after the request, busy low -> step_req_out rises every 4*2**LOG_MAX_SPEED cycles. With speed_in=0, no request is issued over 10000 cycles and paused_out=1.
- Handshake: hold step_ack_in low for 50 cycles -> step_req_out stays high throughout and extra carries do not queue a second step. After ack, hold engine_busy_in high for 20 cycles, then low -> FSM returns to IDLE.
- Priority/collision: click edge during STEP_WAIT, then move the cursor -> write occurs only after busy falls, at the originally latched address. Click edge and carry in the same cycle -> write precedes step_req_out.
- SINGLE_STEP_EN: speed_in=0, 3 presses of step_btn_in -> exactly 3 request/ack pairs. With speed_in=4, presses add no extra requests.
